// File: rtl/key_tone_if.sv
// Key-switch inputs and audio/status outputs of the key tone generator.
// master drives the raw keys; slave is the tone generator itself.
interface key_tone_if;
   logic [7:0] key;
   logic       ain;
   logic       playing;
   logic [2:0] note_idx;

   modport master (
      output key,
      input  ain,
      input  playing,
      input  note_idx
   );

   modport slave (
      input  key,
      output ain,
      output playing,
      output note_idx
   );
endinterface

// File: rtl/key_tone_gen.sv
// Eight debounced piano keys -> lowest pressed key picks a C4..C5 note, emitted as a
// volume-gated 1-bit square wave for the amplifier AIN pin.
module key_tone_gen #(
   parameter int unsigned CLK_HZ          = 100_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned VOL_BITS        = 6
) (
   input logic       clk,
   input logic       rst_n,
   key_tone_if.slave bus
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   // Note frequencies held in centi-Hz so the half period rounds with integer math.
   function automatic logic [17:0] calc_half(input int unsigned idx);
      longint unsigned f_chz;
      longint unsigned num;
      case (idx)
         0:       f_chz = 64'd26163;
         1:       f_chz = 64'd29366;
         2:       f_chz = 64'd32963;
         3:       f_chz = 64'd34923;
         4:       f_chz = 64'd39200;
         5:       f_chz = 64'd44000;
         6:       f_chz = 64'd49388;
         default: f_chz = 64'd52325;
      endcase
      num = 64'(CLK_HZ) * 64'd100 + f_chz;
      return 18'(num / (64'd2 * f_chz));
   endfunction

   localparam logic [17:0] HALF [8] = '{
      calc_half(0), calc_half(1), calc_half(2), calc_half(3),
      calc_half(4), calc_half(5), calc_half(6), calc_half(7)
   };

   logic [7:0]          sync1_q, key_s_q;
   logic [7:0]          key_db_q, key_db_d;
   logic [CntW-1:0]     cnt_q [8];
   logic [CntW-1:0]     cnt_d [8];
   logic                playing_q, playing_d;
   logic [2:0]          note_q, note_d, sel;
   logic [17:0]         half_cnt_q, half_cnt_d, half_max;
   logic                tone_q, tone_d, restart;
   logic [VOL_BITS-1:0] vol_cnt_q, vol_cnt_d;
   logic                ain_q, ain_d;

   always_comb begin
      key_db_d = key_db_q;
      for (int i = 0; i < 8; i++) begin
         cnt_d[i] = '0;
         if (key_s_q[i] != key_db_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               key_db_d[i] = key_s_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CntW'(1);
            end
         end
      end
   end

   // Lowest index wins: scan upward and keep the first hit.
   always_comb begin
      logic found;
      sel   = '0;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (key_db_q[i] && !found) begin
            sel   = 3'(i);
            found = 1'b1;
         end
      end
   end

   assign playing_d = |key_db_q;
   assign note_d    = playing_d ? sel : note_q;
   assign restart   = playing_d && (!playing_q || (note_d != note_q));
   assign half_max  = HALF[note_q] - 18'd1;

   always_comb begin
      half_cnt_d = '0;
      tone_d     = 1'b0;
      if (playing_d && !restart) begin
         if (half_cnt_q == half_max) begin
            tone_d = ~tone_q;
         end else begin
            half_cnt_d = half_cnt_q + 18'd1;
            tone_d     = tone_q;
         end
      end
   end

   assign vol_cnt_d = vol_cnt_q + VOL_BITS'(1);
   assign ain_d     = playing_q & tone_q & (vol_cnt_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= '0;
         key_s_q    <= '0;
         key_db_q   <= '0;
         for (int i = 0; i < 8; i++) begin
            cnt_q[i] <= '0;
         end
         playing_q  <= 1'b0;
         note_q     <= '0;
         half_cnt_q <= '0;
         tone_q     <= 1'b0;
         vol_cnt_q  <= '0;
         ain_q      <= 1'b0;
      end else begin
         sync1_q    <= bus.key;
         key_s_q    <= sync1_q;
         key_db_q   <= key_db_d;
         for (int i = 0; i < 8; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         playing_q  <= playing_d;
         note_q     <= note_d;
         half_cnt_q <= half_cnt_d;
         tone_q     <= tone_d;
         vol_cnt_q  <= vol_cnt_d;
         ain_q      <= ain_d;
      end
   end

   assign bus.ain      = ain_q;
   assign bus.playing  = playing_q;
   assign bus.note_idx = note_q;

endmodule

// File: tb/tb_key_tone_gen.sv
// Self-checking bench for key_tone_gen: directed sequences, a vector table and random key
// activity, all compared against a phase-arithmetic reference model.
module tb_key_tone_gen;

   localparam int unsigned CLK_HZ = 100_000;
   localparam int unsigned DB     = 4;
   localparam int unsigned VB     = 6;
   localparam int          VolPer = 1 << VB;
   localparam int          Lat    = 2 + DB + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   key_tone_if kt_if ();

   key_tone_gen #(
      .CLK_HZ         (CLK_HZ),
      .DEBOUNCE_CYCLES(DB),
      .VOL_BITS       (VB)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (kt_if.slave)
   );

   always #5 clk = ~clk;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Reference model: state as seen after edge m_n since reset release.
   int         m_half [8];
   int         m_n, m_start;
   int         m_run [8];
   logic [7:0] m_s1, m_s2, m_db;
   logic       m_play, m_tone, m_ain;
   logic [2:0] m_note;

   task automatic model_reset();
      m_n = 0; m_start = 0;
      m_s1 = '0; m_s2 = '0; m_db = '0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
      m_play = 1'b0; m_tone = 1'b0; m_ain = 1'b0; m_note = '0;
   endtask

   task automatic model_edge();
      logic       new_play;
      logic [2:0] new_note;
      int         lowest;
      m_ain = m_play && m_tone && ((m_n % VolPer) == 0);
      m_n++;
      lowest = -1;
      for (int i = 7; i >= 0; i--) if (m_db[i]) lowest = i;
      new_play = (lowest >= 0);
      new_note = new_play ? 3'(lowest) : m_note;
      // A key flips once DB consecutive synchronized samples have disagreed with it.
      for (int i = 0; i < 8; i++) begin
         if (m_s2[i] == m_db[i]) m_run[i] = 0;
         else begin
            m_run[i]++;
            if (m_run[i] == int'(DB)) begin
               m_db[i]  = m_s2[i];
               m_run[i] = 0;
            end
         end
      end
      if (new_play && (!m_play || new_note != m_note)) m_start = m_n;
      m_play = new_play;
      m_note = new_note;
      m_tone = m_play ? ((((m_n - m_start) / m_half[m_note]) % 2) == 1) : 1'b0;
      m_s2 = m_s1;
      m_s1 = kt_if.key;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One clock: model advances on the edge, DUT compared on the falling edge.
   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      vec_cnt++;
      if (kt_if.ain !== m_ain || kt_if.playing !== m_play || kt_if.note_idx !== m_note) begin
         err_cnt++;
         $display("FAIL model_cmp t=%0t: ain/playing/note_idx got %b/%b/%0d expected %b/%b/%0d",
                  $time, kt_if.ain, kt_if.playing, kt_if.note_idx, m_ain, m_play, m_note);
      end
   endtask

   // which: 0 = playing, 1 = internal tone. Returns -1 if the bound expires.
   task automatic wait_sig(input int which, input logic level, input int max, output int cyc);
      logic v;
      cyc = -1;
      for (int k = 1; k <= max; k++) begin
         step();
         v = (which == 0) ? kt_if.playing : dut.tone_q;
         if (v === level) begin
            cyc = k;
            break;
         end
      end
   endtask

   typedef struct {
      logic [7:0] key;
      int         hold;
      logic       play;
      logic [2:0] note;
   } vec_t;

   vec_t tbl [9];
   real  freq [8] = '{261.63, 293.66, 329.63, 349.23, 392.00, 440.00, 493.88, 523.25};

   initial begin
      int cyc, a, b, bad, last, pulses;

      tbl[0] = '{key: 8'h01, hold: 4,  play: 1'b0, note: 3'd2};
      tbl[1] = '{key: 8'h01, hold: 10, play: 1'b1, note: 3'd0};
      tbl[2] = '{key: 8'hFF, hold: 3,  play: 1'b1, note: 3'd0};
      tbl[3] = '{key: 8'hFE, hold: 20, play: 1'b1, note: 3'd1};
      tbl[4] = '{key: 8'hC0, hold: 20, play: 1'b1, note: 3'd6};
      tbl[5] = '{key: 8'h80, hold: 20, play: 1'b1, note: 3'd7};
      tbl[6] = '{key: 8'h00, hold: 20, play: 1'b0, note: 3'd7};
      tbl[7] = '{key: 8'h28, hold: 20, play: 1'b1, note: 3'd3};
      tbl[8] = '{key: 8'h00, hold: 20, play: 1'b0, note: 3'd3};
      for (int i = 0; i < 8; i++) m_half[i] = $rtoi(real'(CLK_HZ) / (2.0 * freq[i]) + 0.5);

      // Reset and idle.
      kt_if.key = '0;
      model_reset();
      for (int i = 0; i < 5; i++) step();
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (kt_if.ain !== 1'b0 || kt_if.playing !== 1'b0 || kt_if.note_idx !== 3'd0) bad++;
      end
      chk("idle_quiet", bad, 0);

      // Single held key: latency, first tone edge, half period, ain pulse spacing.
      kt_if.key = 8'h20;
      wait_sig(0, 1'b1, 50, cyc);
      chk("press_latency_k5", cyc, Lat);
      chk("note_k5", int'(kt_if.note_idx), 5);
      wait_sig(1, 1'b1, 400, cyc);
      chk("first_tone_rise_k5", cyc, m_half[5]);
      wait_sig(1, 1'b0, 400, cyc);
      chk("tone_high_half_k5", cyc, m_half[5]);
      bad = 0; last = -1; pulses = 0;
      for (int k = 0; k < 4 * m_half[5]; k++) begin
         step();
         if (kt_if.ain === 1'b1) begin
            if (last >= 0 && ((k - last) % VolPer) != 0) bad++;
            last = k;
            pulses++;
         end
      end
      chk("ain_gap_multiple", bad, 0);
      chk("ain_pulses_seen", int'(pulses > 2), 1);

      // Release: playing falls after full latency, note holds, ain silent afterwards.
      kt_if.key = 8'h00;
      wait_sig(0, 1'b0, 50, cyc);
      chk("release_latency", cyc, Lat);
      chk("release_note_hold", int'(kt_if.note_idx), 5);
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         step();
         if (kt_if.ain !== 1'b0) bad++;
      end
      chk("release_ain_silent", bad, 0);

      // Bounce rejection on key[0], then a clean hold.
      for (int c = 0; c < 20; c++) begin
         if (c % 2 == 0) kt_if.key[0] = ~kt_if.key[0];
         step();
      end
      chk("bounce_no_play", int'(kt_if.playing), 0);
      kt_if.key = 8'h01;
      wait_sig(0, 1'b1, 50, cyc);
      chk("bounce_then_hold_latency", cyc, Lat);
      kt_if.key = 8'h00;
      wait_sig(0, 1'b0, 50, cyc);

      // Priority and handoff from key 3 to key 7.
      kt_if.key = 8'h88;
      for (int k = 0; k < 20; k++) step();
      chk("priority_note", int'(kt_if.note_idx), 3);
      kt_if.key = 8'h80;
      for (int k = 0; k < Lat - 1; k++) step();
      chk("handoff_hold_old", int'(kt_if.note_idx), 3);
      step();
      chk("handoff_note", int'(kt_if.note_idx), 7);
      chk("handoff_tone_restart", int'(dut.tone_q), 0);
      wait_sig(1, 1'b1, 400, cyc);
      chk("handoff_first_rise", cyc, m_half[7]);
      wait_sig(1, 1'b0, 400, a);
      wait_sig(1, 1'b1, 400, b);
      chk("period_k7", a + b, 2 * m_half[7]);

      // Reset mid-note on key[2].
      kt_if.key = 8'h04;
      for (int k = 0; k < 30; k++) step();
      chk("pre_reset_playing", int'(kt_if.playing), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("reset_async_playing", int'(kt_if.playing), 0);
      chk("reset_async_ain", int'(kt_if.ain), 0);
      chk("reset_async_note", int'(kt_if.note_idx), 0);
      model_reset();
      for (int k = 0; k < 3; k++) step();
      rst_n = 1'b1;
      wait_sig(0, 1'b1, 50, cyc);
      chk("post_reset_relatch", cyc, Lat);
      chk("post_reset_note", int'(kt_if.note_idx), 2);
      kt_if.key = 8'h00;
      wait_sig(0, 1'b0, 50, cyc);

      // Vector table.
      for (int v = 0; v < 9; v++) begin
         kt_if.key = tbl[v].key;
         for (int k = 0; k < tbl[v].hold; k++) step();
         chk($sformatf("tbl%0d_playing", v), int'(kt_if.playing), int'(tbl[v].play));
         chk($sformatf("tbl%0d_note", v), int'(kt_if.note_idx), int'(tbl[v].note));
      end

      // Random key activity, including sub-debounce glitches and long holds.
      for (int r = 0; r < 120; r++) begin
         int hold;
         if ($urandom_range(0, 3) == 0) kt_if.key = 8'($urandom);
         else kt_if.key[$urandom_range(0, 7)] = 1'($urandom);
         hold = ($urandom_range(0, 3) == 0) ? $urandom_range(50, 400) : $urandom_range(1, 12);
         for (int k = 0; k < hold; k++) step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/key_tone_gen.md
# key_tone_gen

Turns the piano's eight raw key switches into the single-bit audio drive that feeds the amplifier output stage's AIN pin. Each key is synchronized and debounced. The lowest-numbered pressed key selects a note from C4 to C5, and the block produces that note's square wave. The waveform is gated down to a short pulse once every 2^VOL_BITS cycles, which keeps the volume low. The block sits directly upstream of the amplifier stage.

## Interface
- CLK_HZ, 100_000_000: clock frequency; sets the note half-period constants.
- DEBOUNCE_CYCLES, 1_000_000: consecutive agreeing samples needed to accept a key change (10 ms at 100 MHz).
- VOL_BITS, 6: width of the volume gate counter; ain pulses at most once every 2^VOL_BITS cycles.
- clk  in  1  system clock; all state is updated on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- key  in  8  raw, asynchronous, bouncy key switches; key[0] = C4 … key[7] = C5.
- ain  out  1  audio drive to the amplifier AIN pin; registered.
- playing  out  1  high while a debounced key is held; registered.
- note_idx  out  3  index of the selected key; holds its last value when idle; registered.

## Operation
- Reset (rst_n low, asynchronous): clears every register.
  - Outputs: ain=0, playing=0, note_idx=0.
  - Internal state: synchronizers, debounce counters, stable key states, half_cnt, tone_q and vol_cnt all go to 0.
- Synchronizer: two flip-flops per key; the second-stage output is key_s.
- Debounce, per key:
  - A counter cnt tracks how long key_s has disagreed with the stable value key_db.
  - When key_s equals key_db, cnt resets to 0.
  - Otherwise cnt increments each cycle.
  - When cnt = DEBOUNCE_CYCLES-1 and key_s still differs, key_db takes the value of key_s and cnt returns to 0.
- Note selection: sel is the lowest index i with key_db[i]=1; ties always go to the lower index.
  - If no key_db bit is set: playing←0, and note_idx holds.
  - Otherwise: playing←1, note_idx←sel.
- Half-period table: HALF[i] = round(CLK_HZ / (2·f_i)), with f = 261.63, 293.66, 329.63, 349.23, 392.00, 440.00, 493.88, 523.25 Hz.
  - At 100 MHz: HALF[5]=113636, HALF[7]=95557.
  - half_cnt is 18 bits wide.
- Tone counter:
  - While playing: half_cnt counts from 0 to HALF[note_idx]-1. On the cycle it reaches HALF-1, tone_q toggles and half_cnt returns to 0.
  - Note change: on any cycle where playing rises or note_idx changes, half_cnt←0 and tone_q←0, which restarts the phase.
  - While not playing: half_cnt=0 and tone_q=0.
- Volume gate: vol_cnt is VOL_BITS wide and free-runs from reset, wrapping from 2^VOL_BITS-1 to 0.
- Output: ain ← playing & tone_q & (vol_cnt==0), registered.

## Timing
- Key to debounced state: a clean edge on key[i] appears on key_db[i] 2+DEBOUNCE_CYCLES cycles later (2 synchronizer stages, then DEBOUNCE_CYCLES disagreeing samples).
- Debounced state to outputs: playing and note_idx update 1 cycle after key_db changes.
- First tone edge: tone_q first rises HALF[note_idx] cycles after playing rises.
- Square-wave period: exactly 2·HALF[note_idx] cycles.
- ain duty: during the high half of tone_q, ain is high for 1 cycle in every 2^VOL_BITS. During the low half, ain stays 0.
- Release: ain=0 starting 1 cycle after playing falls. No tail and no fade.
- Simultaneous press and release on the same cycle: selection is re-evaluated from key_db every cycle, so note_idx follows the lowest remaining key with 1-cycle latency.
- Bounce shorter than DEBOUNCE_CYCLES: produces no change on key_db.
- Reset mid-note: outputs go to 0 asynchronously. After rst_n deasserts, a key that is still held must be re-debounced before playing rises again.

## Test plan
- Reset and idle:
  - Stimulus: hold rst_n low for 5 cycles, release it, keep key=0 for 1000 cycles.
  - Response: ain=0, playing=0 and note_idx=0 throughout.
- Single held key (DEBOUNCE_CYCLES=4, VOL_BITS=6):
  - Stimulus: assert key[5] and hold it.
  - Response: playing rises 7 cycles after the edge; note_idx=5; tone_q toggles every 113636 cycles; ain pulses are exactly 64 cycles apart and occur only while tone_q=1.
- Bounce rejection (DEBOUNCE_CYCLES=4):
  - Stimulus: toggle key[0] every 2 cycles for 20 cycles, then hold it high.
  - Response: playing stays 0 during the bounce, then rises 7 cycles after the final edge.
- Priority and handoff:
  - Stimulus: hold key[3] and key[7] together, then release key[3].
  - Response: note_idx=3 while both are held. After release it becomes 7 with tone_q restarted at 0, and the period becomes 191114 cycles.
- Reset mid-note:
  - Stimulus: pull rst_n low while key[2] is playing.
  - Response: ain and playing drop in the same cycle. After rst_n rises, playing returns only after the full debounce latency.
- Release:
  - Stimulus: drop all keys.
  - Response: playing falls 2+DEBOUNCE_CYCLES+1 cycles later; ain=0 from the next cycle on; note_idx holds its last value.
